// File: rtl/jtcop_colmix_fade.sv
// Colour mixer: priority-PROM layer selection, palette lookup and frame-based brightness fade.
// The video path is a 5-stage pipeline advanced by pxl_cen; CPU palette access and the fade run on clk.
module jtcop_colmix_fade #(
    parameter int NL   = 4,
    parameter int PW   = 8,
    parameter int PRIW = 3,
    parameter int SW   = $clog2(NL),
    localparam int AW  = SW + PW,
    localparam int PA  = PRIW + 2 * NL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pxl_cen,
    input  logic             LHBL,
    input  logic             LVBL,
    input  logic [1:0]       pal_cs,
    input  logic             fade_cs,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [15:0]      cpu_dout,
    input  logic [1:0]       dsn,
    output logic [15:0]      cpu_din,
    input  logic [PRIW-1:0]  prisel,
    input  logic [PA-1:0]    prog_addr,
    input  logic [SW-1:0]    prom_din,
    input  logic             prom_we,
    input  logic [NL*PW-1:0] lyr_pxl,
    input  logic [NL-1:0]    gfx_en,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             LHBL_dly,
    output logic             LVBL_dly,
    output logic             fade_busy
);

    localparam int PD   = 1 << PA;
    localparam int PALD = 1 << AW;

    logic [SW-1:0]    prom_mem [PD];
    logic [15:0]      rg_mem   [PALD];
    logic [7:0]       b_mem    [PALD];

    logic [NL-1:0]    opaque_s;
    logic [NL-1:0]    prio_s;
    logic [PW-1:0]    sel_pxl_s;

    logic [NL*PW-1:0] pxl_s1_r;
    logic [PA-1:0]    prom_addr_s1_r;
    logic [NL*PW-1:0] pxl_s2_r;
    logic [SW-1:0]    sel_s2_r;
    logic [AW-1:0]    pal_addr_s3_r;
    logic [15:0]      rg_s4_r;
    logic [7:0]       b_s4_r;
    logic [3:0]       lhbl_sh_r;
    logic [3:0]       lvbl_sh_r;

    logic [7:0]       lvl_r;
    logic [7:0]       target_r;
    logic [3:0]       period_r;
    logic [3:0]       step_r;
    logic [3:0]       frame_cnt_r;
    logic             lvbl_last_r;

    logic             vb_fall_s;
    logic             fade_we_s;
    logic [3:0]       cnt_inc_s;
    logic             step_due_s;
    logic [7:0]       lvl_step_s;

    // Brightness scaling: (comp * (lvl + 1)) >> 8, so full level is an identity.
    function automatic logic [7:0] scale(input logic [7:0] comp, input logic [7:0] lvl);
        return 8'((16'(comp) * (16'(lvl) + 16'd1)) >> 8);
    endfunction

    // Per-layer opacity and priority bits that form the PROM address.
    always_comb begin
        opaque_s = '0;
        prio_s   = '0;
        for (int j = 0; j < NL; j++) begin
            opaque_s[j] = (|lyr_pxl[j*PW +: 4]) & gfx_en[j];
            prio_s[j]   = lyr_pxl[j*PW + PW - 1];
        end
    end

    // Pick the pixel of the selected layer; out-of-range selectors fall back to layer 0.
    always_comb begin
        sel_pxl_s = pxl_s2_r[PW-1:0];
        for (int j = 1; j < NL; j++) begin
            sel_pxl_s = (int'(sel_s2_r) == j) ? pxl_s2_r[j*PW +: PW] : sel_pxl_s;
        end
    end

    // CPU palette writes with byte enables and priority PROM download.
    always_ff @(posedge clk) begin
        if (pal_cs[0] && !dsn[1]) rg_mem[cpu_addr][15:8] <= cpu_dout[15:8];
        if (pal_cs[0] && !dsn[0]) rg_mem[cpu_addr][7:0]  <= cpu_dout[7:0];
        if (pal_cs[1] && !dsn[0]) b_mem[cpu_addr]        <= cpu_dout[7:0];
        if (prom_we)              prom_mem[prog_addr]    <= prom_din;
    end

    // CPU palette read port, one clock of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_din <= 16'd0;
        end else begin
            cpu_din <= pal_cs[0] ? rg_mem[cpu_addr] : {8'hff, b_mem[cpu_addr]};
        end
    end

    // Video pipeline: S1 capture, S2 PROM, S3 palette address, S4 palette, S5 fade/blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl_s1_r       <= '0;
            prom_addr_s1_r <= '0;
            pxl_s2_r       <= '0;
            sel_s2_r       <= '0;
            pal_addr_s3_r  <= '0;
            rg_s4_r        <= 16'd0;
            b_s4_r         <= 8'd0;
            lhbl_sh_r      <= 4'd0;
            lvbl_sh_r      <= 4'd0;
            LHBL_dly       <= 1'b0;
            LVBL_dly       <= 1'b0;
            red            <= 8'd0;
            green          <= 8'd0;
            blue           <= 8'd0;
        end else if (pxl_cen) begin
            pxl_s1_r       <= lyr_pxl;
            prom_addr_s1_r <= {prisel, prio_s, opaque_s};
            pxl_s2_r       <= pxl_s1_r;
            sel_s2_r       <= prom_mem[prom_addr_s1_r];
            pal_addr_s3_r  <= {sel_s2_r, sel_pxl_s};
            rg_s4_r        <= rg_mem[pal_addr_s3_r];
            b_s4_r         <= b_mem[pal_addr_s3_r];
            lhbl_sh_r      <= {lhbl_sh_r[2:0], LHBL};
            lvbl_sh_r      <= {lvbl_sh_r[2:0], LVBL};
            LHBL_dly       <= lhbl_sh_r[3];
            LVBL_dly       <= lvbl_sh_r[3];
            // Blanking is taken from the stage that becomes LHBL_dly/LVBL_dly on this same edge.
            red            <= (lhbl_sh_r[3] && lvbl_sh_r[3]) ? scale(rg_s4_r[7:0],  lvl_r) : 8'd0;
            green          <= (lhbl_sh_r[3] && lvbl_sh_r[3]) ? scale(rg_s4_r[15:8], lvl_r) : 8'd0;
            blue           <= (lhbl_sh_r[3] && lvbl_sh_r[3]) ? scale(b_s4_r,        lvl_r) : 8'd0;
        end
    end

    assign vb_fall_s  = lvbl_last_r & ~LVBL;
    assign fade_we_s  = fade_cs & ~dsn[0];
    assign fade_busy  = (lvl_r != target_r);

    // Next brightness one step toward the target, clamped so it never overshoots.
    always_comb begin
        cnt_inc_s  = frame_cnt_r + 4'd1;
        step_due_s = (cnt_inc_s >= period_r);
        lvl_step_s = lvl_r;
        if (lvl_r > target_r) begin
            lvl_step_s = ((lvl_r - target_r) <= {4'd0, step_r}) ? target_r : (lvl_r - {4'd0, step_r});
        end else if (lvl_r < target_r) begin
            lvl_step_s = ((target_r - lvl_r) <= {4'd0, step_r}) ? target_r : (lvl_r + {4'd0, step_r});
        end else begin
            lvl_step_s = lvl_r;
        end
    end

    // Fade control: a register write takes precedence over a coincident frame tick.
    // lvbl_last_r resets low so a reset released inside vblank cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_r       <= 8'hff;
            target_r    <= 8'hff;
            period_r    <= 4'd1;
            step_r      <= 4'd1;
            frame_cnt_r <= 4'd0;
            lvbl_last_r <= 1'b0;
        end else begin
            lvbl_last_r <= LVBL;
            if (fade_we_s) begin
                target_r    <= cpu_dout[7:0];
                period_r    <= (cpu_dout[11:8]  == 4'd0) ? 4'd1 : cpu_dout[11:8];
                step_r      <= (cpu_dout[15:12] == 4'd0) ? 4'd1 : cpu_dout[15:12];
                frame_cnt_r <= 4'd0;
            end else if (vb_fall_s) begin
                if (step_due_s) begin
                    frame_cnt_r <= 4'd0;
                    lvl_r       <= lvl_step_s;
                end else begin
                    frame_cnt_r <= cnt_inc_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtcop_colmix_fade.sv
// Self-checking bench for jtcop_colmix_fade: random pixels against a frame-level reference model.
module tb_jtcop_colmix_fade;

    localparam int NL = 4, PW = 8, PRIW = 3, SW = 2, AW = 10, PA = 11;

    logic              clk = 1'b0;
    logic              rst_n, pxl_cen, LHBL, LVBL, fade_cs, prom_we;
    logic [1:0]        pal_cs, dsn;
    logic [AW-1:0]     cpu_addr;
    logic [15:0]       cpu_dout, cpu_din;
    logic [PRIW-1:0]   prisel;
    logic [PA-1:0]     prog_addr;
    logic [SW-1:0]     prom_din;
    logic [NL*PW-1:0]  lyr_pxl;
    logic [NL-1:0]     gfx_en;
    logic [7:0]        red, green, blue;
    logic              LHBL_dly, LVBL_dly, fade_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rg_m   [1024];
    logic [7:0]  b_m    [1024];
    logic [1:0]  prom_m [2048];
    int lvl_m, tgt_m, per_m, step_m, cnt_m;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       h;
        logic       v;
    } exp_t;

    jtcop_colmix_fade #(.NL(NL), .PW(PW), .PRIW(PRIW)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .pal_cs(pal_cs), .fade_cs(fade_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .dsn(dsn), .cpu_din(cpu_din), .prisel(prisel), .prog_addr(prog_addr),
        .prom_din(prom_din), .prom_we(prom_we), .lyr_pxl(lyr_pxl), .gfx_en(gfx_en),
        .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .fade_busy(fade_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int scale_m(input int c, input int l);
        return (c * (l + 1)) / 256;
    endfunction

    function automatic exp_t ref_pixel(input logic [31:0] px, input logic [3:0] en,
                                       input logic [2:0] ps, input logic h, input logic v);
        exp_t e;
        int op = 0, pr = 0, sel, lay, pix, pa;
        for (int j = 0; j < NL; j++) begin
            if (px[j*8 +: 4] != 4'd0 && en[j]) op |= (1 << j);
            if (px[j*8 + 7]) pr |= (1 << j);
        end
        sel = int'(prom_m[ps * 256 + pr * 16 + op]);
        lay = (sel < NL) ? sel : 0;
        pix = int'((px >> (lay * 8)) & 32'hff);
        pa  = sel * 256 + pix;
        e.h = h;
        e.v = v;
        e.r = (h && v) ? 8'(scale_m(int'(rg_m[pa][7:0]),  lvl_m)) : 8'd0;
        e.g = (h && v) ? 8'(scale_m(int'(rg_m[pa][15:8]), lvl_m)) : 8'd0;
        e.b = (h && v) ? 8'(scale_m(int'(b_m[pa]),        lvl_m)) : 8'd0;
        return e;
    endfunction

    task automatic model_fall;
        cnt_m++;
        if (cnt_m >= per_m) begin
            cnt_m = 0;
            if (lvl_m > tgt_m)      lvl_m = (lvl_m - step_m < tgt_m) ? tgt_m : lvl_m - step_m;
            else if (lvl_m < tgt_m) lvl_m = (lvl_m + step_m > tgt_m) ? tgt_m : lvl_m + step_m;
        end
    endtask

    task automatic model_reset;
        lvl_m = 255; tgt_m = 255; per_m = 1; step_m = 1; cnt_m = 0;
    endtask

    task automatic cpu_write(input logic [1:0] cs, input int a, input logic [15:0] d, input logic [1:0] ds);
        pal_cs = cs; cpu_addr = AW'(a); cpu_dout = d; dsn = ds;
        tick;
        pal_cs = 2'b00; dsn = 2'b11;
        if (cs[0] && !ds[0]) rg_m[a][7:0]  = d[7:0];
        if (cs[0] && !ds[1]) rg_m[a][15:8] = d[15:8];
        if (cs[1] && !ds[0]) b_m[a]        = d[7:0];
    endtask

    task automatic prom_write(input int a, input logic [1:0] d);
        prog_addr = PA'(a); prom_din = d; prom_we = 1'b1;
        tick;
        prom_we = 1'b0;
        prom_m[a] = d;
    endtask

    task automatic fade_write(input logic [15:0] d, input logic [1:0] ds, input bit with_fall);
        fade_cs = 1'b1; cpu_dout = d; dsn = ds;
        if (with_fall) LVBL = 1'b0;
        tick;
        fade_cs = 1'b0; dsn = 2'b11;
        if (!ds[0]) begin
            tgt_m = int'(d[7:0]);
            per_m = (d[11:8]  == 4'd0) ? 1 : int'(d[11:8]);
            step_m = (d[15:12] == 4'd0) ? 1 : int'(d[15:12]);
            cnt_m = 0;
        end
    endtask

    task automatic frame;
        LVBL = 1'b1; tick;
        LVBL = 1'b0; tick; model_fall();
        tick;
        LVBL = 1'b1; tick;
    endtask

    // Runs a flat pixel through the pipeline; with the flat palette every channel reads back lvl.
    task automatic measure(input string tag);
        lyr_pxl = '0; prisel = '0; gfx_en = 4'hf; LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
        repeat (6) tick;
        pxl_cen = 1'b0;
        n_cmp++;
        if ({red, green, blue} !== {3{8'(scale_m(255, lvl_m))}}) begin
            n_err++;
            $display("FAIL %s lvl: got r%0d g%0d b%0d, want %0d", tag, red, green, blue, scale_m(255, lvl_m));
        end
        n_cmp++;
        if (fade_busy !== (lvl_m != tgt_m)) begin
            n_err++;
            $display("FAIL %s busy: got %b, want %b", tag, fade_busy, (lvl_m != tgt_m));
        end
    endtask

    task automatic set_flat_palette;
        for (int s = 0; s < NL; s++) begin
            cpu_write(2'b01, s * 256, 16'hffff, 2'b00);
            cpu_write(2'b10, s * 256, 16'h00ff, 2'b00);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if ({red, green, blue, LHBL_dly, LVBL_dly, fade_busy} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got r%h g%h b%h h%b v%b busy%b, want all 0",
                     red, green, blue, LHBL_dly, LVBL_dly, fade_busy);
        end
        rst_n = 1'b1;
        tick;
        model_reset();
    endtask

    task automatic test_basic_lookup;
        for (int a = 0; a < 2048; a++) prom_write(a, 2'd0);
        cpu_write(2'b01, 0, 16'h0000, 2'b00);
        cpu_write(2'b10, 0, 16'h0000, 2'b00);
        cpu_write(2'b01, 12'h015, 16'h3344, 2'b00);
        cpu_write(2'b10, 12'h015, 16'h0055, 2'b00);
        lyr_pxl = '0; gfx_en = 4'hf; prisel = '0; LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
        repeat (6) tick;
        n_cmp++;
        if ({red, LHBL_dly, LVBL_dly} !== {8'h00, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL lookup_flush: got r%h h%b v%b, want r00 h1 v1", red, LHBL_dly, LVBL_dly);
        end
        lyr_pxl = 32'h0000_0015;
        repeat (4) tick;
        n_cmp++;
        if ({red, green, blue} !== 24'h000000) begin
            n_err++;
            $display("FAIL lookup_early: got %h%h%h after 4 pulses, want 000000", red, green, blue);
        end
        tick;
        n_cmp++;
        if ({red, green, blue} !== 24'h443355) begin
            n_err++;
            $display("FAIL lookup_latency: got r%h g%h b%h, want r44 g33 b55", red, green, blue);
        end
        pxl_cen = 1'b0;
    endtask

    task automatic test_layer_disable;
        prom_write(11'b000_0000_0101, 2'd2);
        cpu_write(2'b01, 12'h207, 16'hAABB, 2'b00);
        cpu_write(2'b10, 12'h207, 16'h00CC, 2'b00);
        lyr_pxl = 32'h0007_0015; gfx_en = 4'b1011; pxl_cen = 1'b1;
        repeat (5) tick;
        n_cmp++;
        if ({red, green, blue} !== 24'h443355) begin
            n_err++;
            $display("FAIL layer2_disabled: got %h%h%h, want 443355", red, green, blue);
        end
        gfx_en = 4'hf;
        repeat (5) tick;
        n_cmp++;
        if ({red, green, blue} !== 24'hBBAACC) begin
            n_err++;
            $display("FAIL layer2_enabled: got %h%h%h, want BBAACC", red, green, blue);
        end
        pxl_cen = 1'b0;
    endtask

    task automatic load_random;
        for (int a = 0; a < 2048; a++) prom_write(a, 2'($urandom));
        for (int a = 0; a < 1024; a++) cpu_write(2'b01, a, 16'($urandom), 2'b00);
        for (int a = 0; a < 1024; a++) cpu_write(2'b10, a, 16'($urandom), 2'b00);
    endtask

    task automatic test_palette_rw;
        int a;
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 1023));
            if (i == 2) cpu_write(2'b01, a, 16'($urandom), 2'b10);
            if (i == 3) cpu_write(2'b01, a, 16'($urandom), 2'b01);
            if (i == 4) cpu_write(2'b10, a, 16'($urandom), 2'b01);
            pal_cs = (i % 2 == 0) ? 2'b11 : 2'b01; cpu_addr = AW'(a); dsn = 2'b11;
            tick;
            n_cmp++;
            if (cpu_din !== rg_m[a]) begin
                n_err++;
                $display("FAIL rg_read @%0h: got %h, want %h", a, cpu_din, rg_m[a]);
            end
            pal_cs = 2'b10;
            tick;
            n_cmp++;
            if (cpu_din !== {8'hff, b_m[a]}) begin
                n_err++;
                $display("FAIL b_read @%0h: got %h, want %h", a, cpu_din, {8'hff, b_m[a]});
            end
            pal_cs = 2'b00;
        end
    endtask

    task automatic test_random_pixels(input int ncyc);
        exp_t q[$];
        exp_t e, cur;
        logic prev_v;
        lyr_pxl = $urandom; gfx_en = 4'($urandom); prisel = 3'($urandom);
        LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
        cur = ref_pixel(lyr_pxl, gfx_en, prisel, 1'b1, 1'b1);
        repeat (5) tick;
        repeat (4) q.push_back(cur);
        for (int i = 0; i < ncyc; i++) begin
            prev_v  = LVBL;
            lyr_pxl = $urandom;
            gfx_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
            prisel  = 3'($urandom);
            LHBL    = ($urandom_range(0, 7) != 0);
            LVBL    = ($urandom_range(0, 7) != 0);
            pxl_cen = 1'($urandom);
            e = ref_pixel(lyr_pxl, gfx_en, prisel, LHBL, LVBL);
            tick;
            if (prev_v && !LVBL) model_fall();
            if (pxl_cen) begin
                q.push_back(e);
                cur = q.pop_front();
            end
            n_cmp++;
            if ({red, green, blue, LHBL_dly, LVBL_dly} !== cur) begin
                n_err++;
                $display("FAIL pixel cyc %0d: got r%h g%h b%h h%b v%b, want r%h g%h b%h h%b v%b",
                         i, red, green, blue, LHBL_dly, LVBL_dly, cur.r, cur.g, cur.b, cur.h, cur.v);
            end
        end
        pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        tick;
    endtask

    task automatic test_fade_step;
        set_flat_palette();
        fade_write(16'h1100, 2'b01, 1'b0);
        measure("fade_dsn0_ignored");
        fade_write(16'hF110, 2'b10, 1'b0);
        for (int f = 0; f < 18; f++) begin
            frame();
            measure("fade_step");
        end
        n_cmp++;
        if ({red, fade_busy} !== {8'd16, 1'b0}) begin
            n_err++;
            $display("FAIL fade_step_clamp: got lvl %0d busy %b, want 16 busy 0", red, fade_busy);
        end
    endtask

    task automatic test_fade_period;
        fade_write(16'h1200, 2'b10, 1'b0);
        for (int f = 0; f < 36; f++) begin
            frame();
            measure("fade_period");
        end
        n_cmp++;
        if ({red, fade_busy} !== {8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL fade_period_end: got lvl %0d busy %b, want 0 busy 0", red, fade_busy);
        end
    endtask

    task automatic test_fade_coincident;
        LVBL = 1'b1; tick;
        fade_write(16'h12FF, 2'b10, 1'b1);
        LVBL = 1'b1; tick;
        measure("coincident_same");
        n_cmp++;
        if (red !== 8'd0) begin
            n_err++;
            $display("FAIL coincident_nostep: got lvl %0d, want 0", red);
        end
        frame(); measure("coincident_f1");
        frame(); measure("coincident_f2");
    endtask

    task automatic test_fade_random;
        logic [15:0] d;
        d = {4'($urandom), 4'($urandom_range(0, 2)), 8'($urandom_range(40, 250))};
        fade_write(d, 2'b10, 1'b0);
        for (int f = 0; f < 600 && lvl_m != tgt_m; f++) begin
            frame();
            measure("fade_random");
        end
        n_cmp++;
        if (lvl_m != tgt_m || fade_busy !== 1'b0) begin
            n_err++;
            $display("FAIL fade_random_done: busy %b lvl_m %0d, want target %0d reached", fade_busy, lvl_m, tgt_m);
        end
    endtask

    task automatic test_reset_mid_fade;
        int a;
        fade_write(16'h1100, 2'b10, 1'b0);
        frame(); frame();
        measure("pre_reset");
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({red, green, blue, LHBL_dly, LVBL_dly, fade_busy} !== 27'd0) begin
            n_err++;
            $display("FAIL async_reset: got r%h g%h b%h h%b v%b busy%b, want all 0",
                     red, green, blue, LHBL_dly, LVBL_dly, fade_busy);
        end
        model_reset();
        LVBL = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            a = (i < 2) ? i * 256 : int'($urandom_range(0, 1023));
            pal_cs = 2'b01; cpu_addr = AW'(a); dsn = 2'b11;
            tick;
            n_cmp++;
            if (cpu_din !== rg_m[a]) begin
                n_err++;
                $display("FAIL reset_keeps_palette @%0h: got %h, want %h", a, cpu_din, rg_m[a]);
            end
        end
        pal_cs = 2'b00;
        fade_write(16'h1100, 2'b10, 1'b0);
        LVBL = 1'b1; tick;
        measure("post_reset_nostep");
        frame();
        measure("post_reset_first_step");
    endtask

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0; fade_cs = 1'b0; prom_we = 1'b0;
        pal_cs = 2'b00; dsn = 2'b11; cpu_addr = '0; cpu_dout = '0; prisel = '0;
        prog_addr = '0; prom_din = '0; lyr_pxl = '0; gfx_en = '0;
        model_reset();
        test_reset();
        test_basic_lookup();
        test_layer_disable();
        load_random();
        test_palette_rw();
        test_random_pixels(400);
        test_fade_step();
        test_fade_period();
        test_fade_coincident();
        test_fade_random();
        test_random_pixels(400);
        test_reset_mid_fade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
